// File: rtl/uart_tx_arbiter.sv
// Four-way round-robin arbiter feeding one 8N1 UART transmitter.
// Each grant latches a single byte; the line is re-arbitrated only after its stop bit.
module uart_tx_arbiter #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic        iCLK_50,
  input  logic        iRST,
  input  logic [3:0]  iREQ,
  input  logic [31:0] iDATA,
  output logic [3:0]  oGNT,
  output logic [1:0]  oOWNER,
  output logic        oBUSY,
  output logic        oUART_TXD
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] BAUD_ONE  = CW'(1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  state_t        r_state, w_state_nxt;
  logic [CW-1:0] r_baud, w_baud_nxt;
  logic [2:0]    r_bit, w_bit_nxt;
  logic [7:0]    r_shift, w_shift_nxt;
  logic [1:0]    r_ptr, w_ptr_nxt;
  logic [3:0]    r_gnt, w_gnt_nxt;
  logic [1:0]    r_owner, w_owner_nxt;
  logic          r_busy, w_busy_nxt;
  logic          r_txd, w_txd_nxt;

  logic [7:0]    w_dbl;
  logic [3:0]    w_rot;
  logic [1:0]    w_off;
  logic [1:0]    w_sel;
  logic          w_baud_done;

  // Rotate the request vector so bit 0 is the requester at the priority pointer.
  assign w_dbl       = {iREQ, iREQ} >> r_ptr;
  assign w_rot       = w_dbl[3:0];
  assign w_sel       = r_ptr + w_off;
  assign w_baud_done = (r_baud == BAUD_LAST);

  always_comb begin
    w_off = 2'd3;
    if (w_rot[0])      w_off = 2'd0;
    else if (w_rot[1]) w_off = 2'd1;
    else if (w_rot[2]) w_off = 2'd2;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_baud_nxt  = w_baud_done ? '0 : r_baud + BAUD_ONE;
    w_bit_nxt   = r_bit;
    w_shift_nxt = r_shift;
    w_ptr_nxt   = r_ptr;
    w_gnt_nxt   = 4'b0000;
    w_owner_nxt = r_owner;
    w_busy_nxt  = r_busy;
    w_txd_nxt   = r_txd;
    case (r_state)
      S_IDLE: begin
        w_baud_nxt = '0;
        if (|iREQ) begin
          w_state_nxt = S_START;
          w_shift_nxt = iDATA[{w_sel, 3'b000} +: 8];
          w_gnt_nxt   = 4'b0001 << w_sel;
          w_owner_nxt = w_sel;
          w_ptr_nxt   = w_sel + 2'd1;
          w_busy_nxt  = 1'b1;
          w_txd_nxt   = 1'b0;
          w_bit_nxt   = 3'd0;
        end
      end
      S_START: begin
        if (w_baud_done) begin
          w_state_nxt = S_DATA;
          w_baud_nxt  = '0;
          w_bit_nxt   = 3'd0;
          w_txd_nxt   = r_shift[0];
        end
      end
      S_DATA: begin
        if (w_baud_done) begin
          w_baud_nxt = '0;
          if (r_bit == 3'd7) begin
            w_state_nxt = S_STOP;
            w_txd_nxt   = 1'b1;
          end else begin
            w_bit_nxt   = r_bit + 3'd1;
            w_shift_nxt = r_shift >> 1;
            w_txd_nxt   = r_shift[1];
          end
        end
      end
      S_STOP: begin
        if (w_baud_done) begin
          w_state_nxt = S_IDLE;
          w_baud_nxt  = '0;
          w_busy_nxt  = 1'b0;
          w_txd_nxt   = 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge iCLK_50 or posedge iRST) begin
    if (iRST) begin
      r_state <= S_IDLE;
      r_baud  <= '0;
      r_bit   <= 3'd0;
      r_ptr   <= 2'd0;
      r_gnt   <= 4'b0000;
      r_owner <= 2'd0;
      r_busy  <= 1'b0;
      r_txd   <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_baud  <= w_baud_nxt;
      r_bit   <= w_bit_nxt;
      r_ptr   <= w_ptr_nxt;
      r_gnt   <= w_gnt_nxt;
      r_owner <= w_owner_nxt;
      r_busy  <= w_busy_nxt;
      r_txd   <= w_txd_nxt;
    end
  end

  // Shift data is only meaningful after a grant loads it, so it carries no reset.
  always_ff @(posedge iCLK_50) begin
    r_shift <= w_shift_nxt;
  end

  assign oGNT      = r_gnt;
  assign oOWNER    = r_owner;
  assign oBUSY     = r_busy;
  assign oUART_TXD = r_txd;

endmodule
